// File: rtl/uart_top.sv
// uart_top: UART loopback datapath. A transmitter serialises a parallel word onto an
// internal serial line, and a receiver on that line deserialises it back.
// Frame: start (0), WIDTH data bits LSB first, even parity, stop (1).
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous, active-low reset
//   start          in   level request; a frame starts whenever TX is idle and start=1
//   TX_data_in     in   word to transmit, latched when a frame starts
//   wait_clock     in   clocks per bit (0 behaves as 1)
//   busy           out  1 while TX is sending a frame
//   stop_bit_err   out  last received frame had stop bit = 0
//   parity_bit_err out  last received frame failed the even-parity check
//   RX_data_out    out  last received data word
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | TX: line high, waiting for start / RX: waiting for line low
// S_START  | TX: driving start bit / RX: waiting for start-bit mid-point
// S_DATA   | data bits, LSB first (tx_idx / rx_idx select the bit)
// S_PARITY | even-parity bit
// S_STOP   | stop bit; RX publishes its results at the stop sample
module uart_top #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] TX_data_in,
    input  logic [15:0]      wait_clock,
    output logic             busy,
    output logic             stop_bit_err,
    output logic             parity_bit_err,
    output logic [WIDTH-1:0] RX_data_out
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [15:0] wc_eff;
    logic [15:0] wc_last;
    logic [15:0] wc_half;

    assign wc_eff  = (wait_clock == 16'd0) ? 16'd1 : wait_clock;
    assign wc_last = wc_eff - 16'd1;
    assign wc_half = wc_eff >> 1;

    logic line;

    // ---------------- transmitter ----------------
    state_t           tx_state, tx_state_n;
    logic [15:0]      tx_cnt, tx_cnt_n;
    logic [IW-1:0]    tx_idx, tx_idx_n;
    logic [WIDTH-1:0] tx_data, tx_data_n;
    logic             tx_tick;

    // >= rather than == so a mid-frame shrink of wait_clock ends the bit instead of
    // letting the counter run around its full range.
    assign tx_tick = (tx_cnt >= wc_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_data  <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_data  <= tx_data_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_tick ? 16'd0 : tx_cnt + 16'd1;
        tx_idx_n   = tx_idx;
        tx_data_n  = tx_data;
        busy       = 1'b1;
        line       = 1'b1;
        case (tx_state)
            S_IDLE: begin
                busy     = 1'b0;
                tx_cnt_n = 16'd0;
                if (start) begin
                    tx_data_n  = TX_data_in;
                    tx_state_n = S_START;
                end
            end
            S_START: begin
                line = 1'b0;
                if (tx_tick) begin
                    tx_idx_n   = '0;
                    tx_state_n = S_DATA;
                end
            end
            S_DATA: begin
                line = tx_data[tx_idx];
                if (tx_tick) begin
                    if (tx_idx == LAST_IDX) tx_state_n = S_PARITY;
                    else                    tx_idx_n   = tx_idx + 1'b1;
                end
            end
            S_PARITY: begin
                line = ^tx_data;
                if (tx_tick) tx_state_n = S_STOP;
            end
            S_STOP: begin
                if (tx_tick) tx_state_n = S_IDLE;
            end
            default: begin
                busy       = 1'b0;
                tx_cnt_n   = 16'd0;
                tx_state_n = S_IDLE;
            end
        endcase
    end

    // ---------------- receiver ----------------
    // rx_cnt in S_START holds the cycle index (within the start bit) being sampled;
    // the falling edge is seen on cycle 0, so the mid-point test is rx_cnt >= wc_half.
    state_t           rx_state, rx_state_n;
    logic [15:0]      rx_cnt, rx_cnt_n;
    logic [IW-1:0]    rx_idx, rx_idx_n;
    logic [WIDTH-1:0] rx_shift, rx_shift_n;
    logic             rx_par, rx_par_n;
    logic [WIDTH-1:0] rx_out_n;
    logic             par_err_n;
    logic             stop_err_n;
    logic             rx_tick;

    assign rx_tick = (rx_cnt >= wc_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state       <= S_IDLE;
            rx_cnt         <= '0;
            rx_idx         <= '0;
            rx_shift       <= '0;
            rx_par         <= 1'b0;
            RX_data_out    <= '0;
            parity_bit_err <= 1'b0;
            stop_bit_err   <= 1'b0;
        end else begin
            rx_state       <= rx_state_n;
            rx_cnt         <= rx_cnt_n;
            rx_idx         <= rx_idx_n;
            rx_shift       <= rx_shift_n;
            rx_par         <= rx_par_n;
            RX_data_out    <= rx_out_n;
            parity_bit_err <= par_err_n;
            stop_bit_err   <= stop_err_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_tick ? 16'd0 : rx_cnt + 16'd1;
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_par_n   = rx_par;
        rx_out_n   = RX_data_out;
        par_err_n  = parity_bit_err;
        stop_err_n = stop_bit_err;
        case (rx_state)
            S_IDLE: begin
                rx_cnt_n = 16'd0;
                if (!line) begin
                    rx_idx_n = '0;
                    // With a one-clock bit the falling-edge sample is already the
                    // start-bit mid-point, so go straight to data.
                    if (wc_half == 16'd0) begin
                        rx_state_n = S_DATA;
                    end else begin
                        rx_cnt_n   = 16'd1;
                        rx_state_n = S_START;
                    end
                end
            end
            S_START: begin
                if (rx_cnt >= wc_half) begin
                    rx_cnt_n   = 16'd0;
                    rx_idx_n   = '0;
                    rx_state_n = line ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_tick) begin
                    rx_shift_n            = rx_shift >> 1;
                    rx_shift_n[WIDTH-1]   = line;
                    if (rx_idx == LAST_IDX) rx_state_n = S_PARITY;
                    else                    rx_idx_n   = rx_idx + 1'b1;
                end
            end
            S_PARITY: begin
                if (rx_tick) begin
                    rx_par_n   = line;
                    rx_state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_tick) begin
                    rx_out_n   = rx_shift;
                    par_err_n  = (rx_par != ^rx_shift);
                    stop_err_n = ~line;
                    rx_state_n = S_IDLE;
                end
            end
            default: begin
                rx_cnt_n   = 16'd0;
                rx_state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_top.sv
module tb_uart_top;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] TX_data_in = '0;
    logic [15:0]  wait_clock = 16'd16;
    logic         busy;
    logic         stop_bit_err;
    logic         parity_bit_err;
    logic [W-1:0] RX_data_out;

    int checks = 0;
    int errors = 0;

    uart_top #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .TX_data_in     (TX_data_in),
        .wait_clock     (wait_clock),
        .busy           (busy),
        .stop_bit_err   (stop_bit_err),
        .parity_bit_err (parity_bit_err),
        .RX_data_out    (RX_data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame starts on a rising edge where start=1 and no frame is in progress;
    // it lasts (W+3)*bit_period cycles, and the edge that ends it cannot start another.
    logic [W-1:0] exp_q[$];
    int           rem = 0;
    int           frame_len = 0;
    int           wce = 1;
    logic [W-1:0] fdata = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem = 0;
            exp_q.delete();
        end else if (rem > 0) begin
            rem--;
        end else if (start) begin
            wce       = (wait_clock == 16'd0) ? 1 : int'(wait_clock);
            frame_len = (W + 3) * wce;
            rem       = frame_len;
            fdata     = TX_data_in;
            exp_q.push_back(fdata);
        end
    end

    function automatic logic exp_line();
        int b;
        if (rem == 0) return 1'b1;
        b = (frame_len - rem) / wce;
        if (b == 0)     return 1'b0;
        if (b <= W)     return fdata[b-1];
        if (b == W + 1) return ^fdata;
        return 1'b1;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            chk("busy", {31'd0, busy}, {31'd0, (rem > 0)});
            chk("line", {31'd0, dut.line}, {31'd0, exp_line()});
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    chk("frame_expected", 32'd0, 32'd1);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    chk("rx_data", {24'd0, RX_data_out}, {24'd0, e});
                    chk("parity_err", {31'd0, parity_bit_err}, 32'd0);
                    chk("stop_err", {31'd0, stop_bit_err}, 32'd0);
                end
            end
        end
        prev_busy = busy;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((busy || rem > 0) && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        int rises;
        logic pb;

        // reset with start requested
        start = 1'b1;
        TX_data_in = 8'hA5;
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rx", {24'd0, RX_data_out}, 32'd0);
        chk("rst_perr", {31'd0, parity_bit_err}, 32'd0);
        chk("rst_serr", {31'd0, stop_bit_err}, 32'd0);
        chk("rst_line", {31'd0, dut.line}, 32'd1);
        start = 1'b0;
        rst = 1'b1;
        repeat (2) tick();

        // single pulse, wait_clock=16, 0xD3: busy length
        wait_clock = 16'd16;
        TX_data_in = 8'hD3;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        chk("busy_len_16", n, 32'd176);
        tick();
        chk("d3_rx", {24'd0, RX_data_out}, 32'hD3);

        // back-to-back 0x00 then 0xFF with start held
        TX_data_in = 8'h00;
        start = 1'b1;
        tick();
        TX_data_in = 8'hFF;
        n = 0;
        while (busy && n < 2000) begin tick(); n++; end
        n = 0;
        while (!busy && n < 100) begin tick(); n++; end
        chk("b2b_gap", n, 32'd1);
        start = 1'b0;
        wait_idle(2000);
        chk("ff_rx", {24'd0, RX_data_out}, 32'hFF);

        // long bit period, start held for two frames
        wait_clock = 16'd2000;
        TX_data_in = 8'b1101_0011;
        start = 1'b1;
        rises = 0;
        pb = busy;
        n = 0;
        while (rises < 2 && n < 50000) begin
            tick();
            if (busy && !pb) rises++;
            pb = busy;
            n++;
        end
        if (n >= 50000) chk("long_timeout", 32'd1, 32'd0);
        start = 1'b0;
        wait_idle(30000);

        // reset mid-DATA, then restart with start held through release
        wait_clock = 16'd10;
        TX_data_in = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (40) tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_rx", {24'd0, RX_data_out}, 32'd0);
        chk("mid_rst_perr", {31'd0, parity_bit_err}, 32'd0);
        chk("mid_rst_serr", {31'd0, stop_bit_err}, 32'd0);
        chk("mid_rst_line", {31'd0, dut.line}, 32'd1);
        repeat (3) tick();
        TX_data_in = 8'h5A;
        start = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        start = 1'b0;
        wait_idle(2000);
        chk("post_rst_rx", {24'd0, RX_data_out}, 32'h5A);

        // one-clock bit periods (1 and 0)
        for (int k = 0; k < 2; k++) begin
            wait_clock = (k == 0) ? 16'd1 : 16'd0;
            TX_data_in = (k == 0) ? 8'h96 : 8'h41;
            start = 1'b1;
            tick();
            start = 1'b0;
            wait_idle(200);
            chk("wc_small_rx", {24'd0, RX_data_out}, (k == 0) ? 32'h96 : 32'h41);
        end

        // randomized frames: pulses and held start with data changing every cycle
        for (int i = 0; i < 20; i++) begin
            int hold;
            wait_clock = 16'($urandom_range(0, 20));
            TX_data_in = 8'($urandom);
            start = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                hold = $urandom_range(1, 3 * (W + 3) * 21);
                for (int c = 0; c < hold; c++) begin
                    tick();
                    TX_data_in = 8'($urandom);
                end
            end else begin
                tick();
            end
            start = 1'b0;
            wait_idle(2000);
            tick();
        end

        tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
